// File: rtl/axilite_master.sv
// AXI4-Lite single-outstanding master: turns one cmd_* request into one AXI
// write or read transaction and returns the slave response plus its cycle count.
module axilite_master #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int LAT_W             = 16
) (
  input  logic                         AXI_ACLK,
  input  logic                         axi_rstn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                  cmd_wdata,
  input  logic [3:0]                   cmd_wstrb,
  input  logic [2:0]                   cmd_prot,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic [LAT_W-1:0]             rsp_latency,
  output logic                         busy,
  output logic                         AXI_AWVALID,
  input  logic                         AXI_AWREADY,
  output logic [AXI_ADDRESS_WIDTH-1:0] AXI_AWADDR,
  output logic [2:0]                   AXI_AWPROT,
  output logic                         AXI_WVALID,
  input  logic                         AXI_WREADY,
  output logic [31:0]                  AXI_WDATA,
  output logic [3:0]                   AXI_WSTRB,
  input  logic                         AXI_BVALID,
  output logic                         AXI_BREADY,
  input  logic [1:0]                   AXI_BRESP,
  output logic                         AXI_ARVALID,
  input  logic                         AXI_ARREADY,
  output logic [AXI_ADDRESS_WIDTH-1:0] AXI_ARADDR,
  output logic [2:0]                   AXI_ARPROT,
  input  logic                         AXI_RVALID,
  output logic                         AXI_RREADY,
  input  logic [31:0]                  AXI_RDATA,
  input  logic [1:0]                   AXI_RRESP
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                       state;
  logic [AXI_ADDRESS_WIDTH-1:0] addr_q;
  logic [2:0]                   prot_q;
  logic                         aw_done, w_done;
  logic                         aw_hs, w_hs, aw_fin, w_fin, lat_run;

  // Both AXI address channels share one registered command address.
  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;
  assign AXI_AWPROT = prot_q;
  assign AXI_ARPROT = prot_q;
  assign busy       = (state != IDLE);

  assign aw_hs   = AXI_AWVALID & AXI_AWREADY;
  assign w_hs    = AXI_WVALID & AXI_WREADY;
  assign aw_fin  = aw_done | aw_hs;
  assign w_fin   = w_done | w_hs;
  assign lat_run = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_RESP);

  always_ff @(posedge AXI_ACLK or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      addr_q      <= '0;
      prot_q      <= '0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_latency <= '0;
    end else begin
      // Counts every AXI-phase cycle, including the final B/R handshake.
      if (lat_run && (rsp_latency != {LAT_W{1'b1}}))
        rsp_latency <= rsp_latency + 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            addr_q      <= cmd_addr;
            prot_q      <= cmd_prot;
            AXI_WDATA   <= cmd_wdata;
            AXI_WSTRB   <= cmd_wstrb;
            rsp_latency <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (cmd_write) begin
              state       <= WR_REQ;
              AXI_AWVALID <= 1'b1;
              AXI_WVALID  <= 1'b1;
            end else begin
              state       <= RD_REQ;
              AXI_ARVALID <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            AXI_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            AXI_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state      <= WR_RESP;
            AXI_BREADY <= 1'b1;
          end
        end
        WR_RESP: begin
          if (AXI_BVALID && AXI_BREADY) begin
            AXI_BREADY <= 1'b0;
            rsp_resp   <= AXI_BRESP;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RD_REQ: begin
          if (AXI_ARVALID && AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (AXI_RVALID && AXI_RREADY) begin
            AXI_RREADY <= 1'b0;
            rsp_rdata  <= AXI_RDATA;
            rsp_resp   <= AXI_RRESP;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: a configurable-delay AXI-Lite slave plus
// one task per scenario with hand-computed expectations.
module tb_axilite_master;

  logic        AXI_ACLK = 1'b0;
  logic        axi_rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic        busy;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic [2:0]  AXI_AWPROT, AXI_ARPROT;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
  logic [1:0]  AXI_BRESP, AXI_RRESP;

  axilite_master dut (
    .AXI_ACLK(AXI_ACLK), .axi_rstn(axi_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_latency(rsp_latency), .busy(busy),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY), .AXI_AWADDR(AXI_AWADDR),
    .AXI_AWPROT(AXI_AWPROT), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_BVALID(AXI_BVALID),
    .AXI_BREADY(AXI_BREADY), .AXI_BRESP(AXI_BRESP), .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY), .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY), .AXI_RDATA(AXI_RDATA),
    .AXI_RRESP(AXI_RRESP)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  int n_cmp = 0;
  int n_err = 0;

  // slave configuration (written by the test sequence only)
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  logic        stray = 1'b0;

  // slave observations (written by the slave process only)
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int          aw_vld_cyc = 0, w_vld_cyc = 0, b_hs_cnt = 0, r_hs_cnt = 0;
  int          aw_stab_err = 0, w_stab_err = 0, bready_early = 0;
  logic        w_seen, prev_awvalid, prev_wvalid;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
  logic [3:0]  last_wstrb = 0;
  logic [2:0]  last_awprot = 0, last_arprot = 0;

  // Slave reacts at the falling edge on outputs registered at the rising edge;
  // a ready/valid set here completes the handshake at the next rising edge.
  initial begin
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_BRESP = 0;
    AXI_ARREADY = 0; AXI_RVALID = 0; AXI_RDATA = 0; AXI_RRESP = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    w_seen = 0; prev_awvalid = 0; prev_wvalid = 0; prev_awaddr = 0; prev_wdata = 0;
    forever begin
      @(negedge AXI_ACLK);
      AXI_BRESP = b_resp_cfg;
      AXI_RDATA = r_data_cfg;
      AXI_RRESP = r_resp_cfg;
      if (!axi_rstn) begin
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_ARREADY = 0; AXI_RVALID = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        w_seen = 0; prev_awvalid = 0; prev_wvalid = 0;
      end else begin
        if (AXI_AWVALID && prev_awvalid && AXI_AWADDR !== prev_awaddr) aw_stab_err++;
        if (AXI_WVALID && prev_wvalid && AXI_WDATA !== prev_wdata) w_stab_err++;
        prev_awvalid = AXI_AWVALID; prev_awaddr = AXI_AWADDR;
        prev_wvalid  = AXI_WVALID;  prev_wdata  = AXI_WDATA;
        if (AXI_BREADY && !w_seen) bready_early++;
        if (AXI_AWVALID) begin
          aw_vld_cyc++;
          AXI_AWREADY = (aw_wait >= aw_delay);
          aw_wait++;
          if (AXI_AWREADY) begin last_awaddr = AXI_AWADDR; last_awprot = AXI_AWPROT; end
        end else begin
          AXI_AWREADY = 0; aw_wait = 0;
        end
        if (AXI_WVALID) begin
          w_vld_cyc++;
          AXI_WREADY = (w_wait >= w_delay);
          w_wait++;
          if (AXI_WREADY) begin w_seen = 1; last_wdata = AXI_WDATA; last_wstrb = AXI_WSTRB; end
        end else begin
          AXI_WREADY = 0; w_wait = 0;
        end
        if (AXI_BREADY) begin
          AXI_BVALID = (b_wait >= b_delay);
          b_wait++;
          if (AXI_BVALID) begin b_hs_cnt++; w_seen = 0; end
        end else begin
          AXI_BVALID = stray; b_wait = 0;
        end
        if (AXI_ARVALID) begin
          AXI_ARREADY = (ar_wait >= ar_delay);
          ar_wait++;
          if (AXI_ARREADY) begin last_araddr = AXI_ARADDR; last_arprot = AXI_ARPROT; end
        end else begin
          AXI_ARREADY = 0; ar_wait = 0;
        end
        if (AXI_RREADY) begin
          AXI_RVALID = (r_wait >= r_delay);
          r_wait++;
          if (AXI_RVALID) r_hs_cnt++;
        end else begin
          AXI_RVALID = stray; r_wait = 0;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    bit ok = 0;
    @(negedge AXI_ACLK); #1;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
    cmd_valid = 1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge AXI_ACLK); #1;
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL cmd_accept timeout: cmd_ready=%b want 1", cmd_ready); end
    @(posedge AXI_ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge AXI_ACLK); #1;
      if (rsp_valid) begin got = 1; break; end
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid); end
  endtask

  task automatic consume;
    rsp_ready = 1;
    @(posedge AXI_ACLK); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    axi_rstn = 0;
    repeat (3) @(negedge AXI_ACLK);
    #1;
    n_cmp++;
    if ({cmd_ready, busy, rsp_valid, AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl got %b want 00000000",
        {cmd_ready, busy, rsp_valid, AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY});
    end
    n_cmp++;
    if ({rsp_rdata, rsp_resp, rsp_latency, AXI_AWADDR, AXI_WDATA, AXI_WSTRB} !== '0) begin
      n_err++; $display("FAIL reset_data rdata=%h resp=%h lat=%0d awaddr=%h wdata=%h want all 0",
        rsp_rdata, rsp_resp, rsp_latency, AXI_AWADDR, AXI_WDATA);
    end
    axi_rstn = 1;
    @(posedge AXI_ACLK); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_basic;
    bit got;
    int aw0, w0, b0;
    aw0 = aw_vld_cyc; w0 = w_vld_cyc; b0 = b_hs_cnt;
    issue(1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010);
    n_cmp++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL wr_busy busy=%b cmd_ready=%b want 1 0", busy, cmd_ready);
    end
    wait_rsp(got);
    if (got) begin
      n_cmp++;
      if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || rsp_latency !== 16'd2) begin
        n_err++; $display("FAIL wr_rsp resp=%h rdata=%h lat=%0d want 0 0 2", rsp_resp, rsp_rdata, rsp_latency);
      end
      n_cmp++;
      if (aw_vld_cyc - aw0 != 1 || w_vld_cyc - w0 != 1) begin
        n_err++; $display("FAIL wr_valid_cycles aw=%0d w=%0d want 1 1", aw_vld_cyc - aw0, w_vld_cyc - w0);
      end
      n_cmp++;
      if (last_awaddr !== 32'h4000_0004 || last_wdata !== 32'hDEAD_BEEF || last_wstrb !== 4'hF || last_awprot !== 3'b010) begin
        n_err++; $display("FAIL wr_bus awaddr=%h wdata=%h wstrb=%h prot=%b want 40000004 deadbeef f 010",
          last_awaddr, last_wdata, last_wstrb, last_awprot);
      end
      consume();
      n_cmp++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || b_hs_cnt - b0 != 1) begin
        n_err++; $display("FAIL wr_done cmd_ready=%b rsp_valid=%b busy=%b bhs=%0d want 1 0 0 1",
          cmd_ready, rsp_valid, busy, b_hs_cnt - b0);
      end
    end
  endtask

  task automatic test_write_wdelay;
    bit got;
    int aw0, w0, b0, be0, st0;
    aw0 = aw_vld_cyc; w0 = w_vld_cyc; b0 = b_hs_cnt; be0 = bready_early; st0 = w_stab_err + aw_stab_err;
    w_delay = 3; b_resp_cfg = 2'b10;
    issue(1'b1, 32'h4000_0100, 32'h1234_5678, 4'h3, 3'b000);
    wait_rsp(got);
    w_delay = 0; b_resp_cfg = 2'b00;
    if (got) begin
      n_cmp++;
      if (aw_vld_cyc - aw0 != 1 || w_vld_cyc - w0 != 4) begin
        n_err++; $display("FAIL wd_valid_cycles aw=%0d w=%0d want 1 4", aw_vld_cyc - aw0, w_vld_cyc - w0);
      end
      n_cmp++;
      if (w_stab_err + aw_stab_err - st0 != 0 || last_wdata !== 32'h1234_5678 || last_wstrb !== 4'h3) begin
        n_err++; $display("FAIL wd_stable errs=%0d wdata=%h wstrb=%h want 0 12345678 3",
          w_stab_err + aw_stab_err - st0, last_wdata, last_wstrb);
      end
      n_cmp++;
      if (bready_early - be0 != 0 || b_hs_cnt - b0 != 1) begin
        n_err++; $display("FAIL wd_bready early=%0d bhs=%0d want 0 1", bready_early - be0, b_hs_cnt - b0);
      end
      n_cmp++;
      if (rsp_resp !== 2'b10 || rsp_latency !== 16'd5 || rsp_rdata !== 32'h0) begin
        n_err++; $display("FAIL wd_rsp resp=%b lat=%0d rdata=%h want 10 5 0", rsp_resp, rsp_latency, rsp_rdata);
      end
      consume();
      repeat (3) @(negedge AXI_ACLK);
      #1;
      n_cmp++;
      if (b_hs_cnt - b0 != 1 || rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL wd_single_rsp bhs=%0d rsp_valid=%b want 1 0", b_hs_cnt - b0, rsp_valid);
      end
    end
  endtask

  task automatic test_read;
    bit got;
    r_delay = 4; r_data_cfg = 32'hC0DE_CAFE;
    issue(1'b0, 32'h4000_220C, 32'h0, 4'h0, 3'b101);
    wait_rsp(got);
    r_delay = 0;
    if (got) begin
      n_cmp++;
      if (rsp_rdata !== 32'hC0DE_CAFE || rsp_resp !== 2'b00 || rsp_latency !== 16'd6) begin
        n_err++; $display("FAIL rd_rsp rdata=%h resp=%b lat=%0d want c0decafe 00 6", rsp_rdata, rsp_resp, rsp_latency);
      end
      n_cmp++;
      if (last_araddr !== 32'h4000_220C || last_arprot !== 3'b101) begin
        n_err++; $display("FAIL rd_ar araddr=%h prot=%b want 4000220c 101", last_araddr, last_arprot);
      end
      consume();
    end
  endtask

  task automatic test_read_err;
    bit got;
    r_resp_cfg = 2'b11; r_data_cfg = 32'h1234_ABCD;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000);
    wait_rsp(got);
    if (got) begin
      n_cmp++;
      if (rsp_resp !== 2'b11 || rsp_rdata !== 32'h1234_ABCD || rsp_latency !== 16'd2) begin
        n_err++; $display("FAIL rderr_rsp resp=%b rdata=%h lat=%0d want 11 1234abcd 2", rsp_resp, rsp_rdata, rsp_latency);
      end
      consume();
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL rderr_idle cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
      end
    end
    r_resp_cfg = 2'b00; r_data_cfg = 32'hA5A5_0001; ar_delay = 2;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
    wait_rsp(got);
    ar_delay = 0;
    if (got) begin
      n_cmp++;
      if (rsp_resp !== 2'b00 || rsp_rdata !== 32'hA5A5_0001 || rsp_latency !== 16'd4) begin
        n_err++; $display("FAIL rdnext_rsp resp=%b rdata=%h lat=%0d want 00 a5a50001 4", rsp_resp, rsp_rdata, rsp_latency);
      end
      consume();
    end
  endtask

  task automatic test_rsp_hold;
    bit got;
    b_resp_cfg = 2'b01;
    issue(1'b1, 32'h0000_0008, 32'h0000_0011, 4'h1, 3'b000);
    wait_rsp(got);
    b_resp_cfg = 2'b00;
    if (got) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge AXI_ACLK); #1;
        n_cmp++;
        if ({rsp_valid, cmd_ready, AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY, AXI_RREADY} !== 7'b1000000 ||
            rsp_latency !== 16'd2 || rsp_resp !== 2'b01 || rsp_rdata !== 32'h0) begin
          n_err++; $display("FAIL hold_%0d ctl=%b lat=%0d resp=%b rdata=%h want 1000000 2 01 0", i,
            {rsp_valid, cmd_ready, AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY, AXI_RREADY},
            rsp_latency, rsp_resp, rsp_rdata);
        end
      end
      consume();
    end
  endtask

  task automatic test_stray;
    stray = 1;
    repeat (3) @(negedge AXI_ACLK);
    #1;
    n_cmp++;
    if (AXI_BREADY !== 1'b0 || AXI_RREADY !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL stray bready=%b rready=%b busy=%b rsp_valid=%b want 0 0 0 0",
        AXI_BREADY, AXI_RREADY, busy, rsp_valid);
    end
    stray = 0;
  endtask

  task automatic test_reset_mid;
    bit got;
    int seen = 0;
    aw_delay = 50;
    issue(1'b1, 32'h4000_0010, 32'hFEED_0001, 4'hF, 3'b001);
    @(negedge AXI_ACLK); #1;
    n_cmp++;
    if (AXI_AWVALID !== 1'b1) begin
      n_err++; $display("FAIL rmid_pre awvalid=%b want 1", AXI_AWVALID);
    end
    axi_rstn = 0;
    #1;
    n_cmp++;
    if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, cmd_ready, busy, rsp_valid} !== 6'b0 ||
        rsp_latency !== 16'd0 || AXI_AWADDR !== 32'h0 || AXI_WDATA !== 32'h0 || AXI_AWPROT !== 3'b0) begin
      n_err++; $display("FAIL rmid_reset ctl=%b lat=%0d awaddr=%h wdata=%h want 000000 0 0 0",
        {AXI_AWVALID, AXI_WVALID, AXI_BREADY, cmd_ready, busy, rsp_valid}, rsp_latency, AXI_AWADDR, AXI_WDATA);
    end
    aw_delay = 0;
    @(negedge AXI_ACLK); #1;
    axi_rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge AXI_ACLK); #1;
      if (rsp_valid || AXI_AWVALID || AXI_WVALID) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL rmid_no_rsp stale_cycles=%0d want 0", seen);
    end
    r_data_cfg = 32'h0BAD_F00D;
    issue(1'b0, 32'h4000_0000, 32'h0, 4'h0, 3'b000);
    wait_rsp(got);
    if (got) begin
      n_cmp++;
      if (rsp_rdata !== 32'h0BAD_F00D || rsp_resp !== 2'b00 || rsp_latency !== 16'd2 || last_araddr !== 32'h4000_0000) begin
        n_err++; $display("FAIL rmid_read rdata=%h resp=%b lat=%0d araddr=%h want 0badf00d 00 2 40000000",
          rsp_rdata, rsp_resp, rsp_latency, last_araddr);
      end
      consume();
    end
  endtask

  initial begin
    axi_rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; cmd_prot = 0; rsp_ready = 0;
    test_reset();
    test_write_basic();
    test_write_wdelay();
    test_read();
    test_read_err();
    test_rsp_hold();
    test_stray();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axilite_master.md
AXILITE_MASTER -- requirements
Module: axilite_master

Interface
REQ-001 Parameter AXI_ADDRESS_WIDTH, default 32: width of cmd_addr, AXI_AWADDR and AXI_ARADDR.
REQ-002 Parameter LAT_W, default 16: width of the rsp_latency counter.
REQ-003 AXI_ACLK  in  1  clock; all logic SHALL be rising-edge.
REQ-004 axi_rstn  in  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid is also high.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  AXI_ADDRESS_WIDTH  byte address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_wstrb  in  4  write byte strobes.
REQ-011 cmd_prot  in  3  AXI protection bits.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  32  read data; 0 for writes.
REQ-015 rsp_resp  out  2  BRESP or RRESP as returned by the slave.
REQ-016 rsp_latency  out  LAT_W  cycles the AXI transaction took.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 AXI4-Lite master ports: AXI_AWVALID/AWREADY/AWADDR/AWPROT, AXI_WVALID/WREADY/WDATA[32]/WSTRB[4], AXI_BVALID/BREADY/BRESP[2], AXI_ARVALID/ARREADY/ARADDR/ARPROT, AXI_RVALID/RREADY/RDATA[32]/RRESP[2]; directions are those of the master side.

Function
REQ-019 States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, the block registers all cmd_* fields and moves to WR_REQ (write) or RD_REQ (read).
REQ-021 WR_REQ: AWVALID and WVALID SHALL assert in the first WR_REQ cycle, carrying the registered addr/prot/data/strb.
REQ-022 WR_REQ: each valid SHALL deassert the cycle after its own handshake, independently of the other channel.
REQ-023 WR_REQ: when both handshakes have completed (same or different cycles), the state SHALL move to WR_RESP.
REQ-024 WR_RESP: BREADY=1; on BVALID&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, and go to RSP.
REQ-025 RD_REQ: ARVALID=1 with registered addr/prot; on ARREADY, go to RD_RESP with ARVALID low next cycle.
REQ-026 RD_RESP: RREADY=1; on RVALID&RREADY, capture RDATA and RRESP, then go to RSP.
REQ-027 VALID outputs SHALL NOT depend combinationally on any READY input; AWADDR/WDATA/WSTRB/ARADDR/PROT SHALL be stable while the corresponding VALID is high.
REQ-028 BREADY and RREADY SHALL be 0 outside WR_RESP and RD_RESP respectively.
REQ-029 RSP: rsp_valid=1 and rsp_* stable until rsp_ready; on rsp_ready, go to IDLE (cmd_ready=1 the following cycle; no back-to-back acceptance in the RSP cycle).
REQ-030 rsp_latency SHALL be cleared on command acceptance, incremented every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP including the B/R handshake cycle, and saturate at all-ones.
REQ-031 A non-OKAY response (SLVERR/DECERR) SHALL be passed through unchanged and SHALL NOT alter the sequencing.
REQ-032 AXI_BVALID or AXI_RVALID arriving in an unexpected state SHALL be ignored (READY stays 0).
REQ-033 No timeout: the block SHALL wait indefinitely for slave handshakes.

Reset
REQ-034 While axi_rstn=0: state IDLE; cmd_ready=0; all AXI VALID/READY outputs 0; rsp_valid=0; rsp_rdata, rsp_resp, rsp_latency, addresses, data and strobes 0; busy=0.
REQ-035 cmd_ready SHALL rise on the first clock edge after reset release.
REQ-036 Reset asserted mid-transaction SHALL abort immediately to the reset values; no response is produced for the aborted command.

Verification
REQ-037 Write 0x40000004 <- 0xDEADBEEF, strb 0xF, slave AWREADY/WREADY/BVALID immediate, BRESP=0 -> AW/W valid 1 cycle, rsp_resp=0, rsp_rdata=0, rsp_latency=2.
REQ-038 Write with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake while WVALID is held with stable WDATA; BREADY rises only after the W handshake; exactly one response.
REQ-039 Read 0x4000220C, slave returns RDATA=0xC0DECAFE, RRESP=0 after 4-cycle RVALID delay -> rsp_rdata=0xC0DECAFE, rsp_resp=0, rsp_latency=6 (ARREADY immediate).
REQ-040 Read returning RRESP=2'b11 -> rsp_resp=2'b11, block returns to IDLE and the next command completes normally.
REQ-041 rsp_ready held low 10 cycles -> rsp_valid and rsp_* stable, cmd_ready=0, no new AXI activity.
REQ-042 axi_rstn pulsed low while AWVALID is high -> all outputs at reset values within the same cycle; a subsequent read to 0x40000000 completes correctly.
